// File: rtl/simon_pkg.sv
// Shared state encoding and LED mode constants for the Simon sequence controller.
package simon_pkg;

    typedef enum logic [2:0] {
        S_INPUT,
        S_PLAY_ON,
        S_PLAY_GAP,
        S_REPEAT,
        S_FAIL,
        S_WIN
    } state_t;

    localparam logic [2:0] LED_MODE_INPUT  = 3'b001;
    localparam logic [2:0] LED_MODE_PLAY   = 3'b010;
    localparam logic [2:0] LED_MODE_REPEAT = 3'b100;
    localparam logic [2:0] LED_MODE_FAIL   = 3'b111;
    localparam logic [2:0] LED_MODE_WIN    = 3'b011;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/simon_tick_timer.sv
// Loadable saturating down-counter; expired is high while the count is zero.
module simon_tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && value != '0) begin
            value <= value - W'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon game controller: owns round/index counters, playback timing,
// response timeout and retry bookkeeping around an external pattern memory.
module simon_seq_ctrl
    import simon_pkg::*;
#(
    parameter int PAT_W         = 4,
    parameter int DEPTH         = 16,
    parameter int STEP_TICKS    = 8,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 64,
    parameter int MAX_RETRIES   = 2,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              pattern_stb,
    input  logic              retry_mode,
    input  logic [PAT_W-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PAT_W-1:0]  mem_wdata,
    output logic              w_en,
    output logic              disp_en,
    output logic [PAT_W-1:0]  disp_pattern,
    output logic [CNT_W-1:0]  count,
    output logic [2:0]        mode_leds,
    output logic              game_over
);

    localparam int TMAX = max3(STEP_TICKS, GAP_TICKS, TIMEOUT_TICKS);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] STEP_LD = TW'(STEP_TICKS - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] TO_LD   =
        (TIMEOUT_TICKS > 0) ? TW'(TIMEOUT_TICKS - 1) : '0;
    localparam logic [RW-1:0] RETRY_INIT = RW'(MAX_RETRIES);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [RW-1:0]     retries_q, retries_d;
    logic              fail_on_q, fail_on_d;

    logic              t_load, t_en, t_expired;
    logic [TW-1:0]     t_val;

    logic              legal;
    logic              more;
    logic              miss;

    assign legal = pattern_stb && (pattern != '0)
                 && ((pattern & (pattern - PAT_W'(1))) == '0);
    assign more  = (CNT_W'(index_q) + CNT_W'(1)) < count_q;

    simon_tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .expired  (t_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INPUT;
            count_q   <= '0;
            index_q   <= '0;
            retries_q <= RETRY_INIT;
            fail_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            retries_q <= retries_d;
            fail_on_q <= fail_on_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        retries_d = retries_q;
        fail_on_d = fail_on_q;
        t_load    = 1'b0;
        t_val     = STEP_LD;
        t_en      = 1'b0;
        miss      = 1'b0;
        unique case (state_q)
            S_INPUT: begin
                if (legal) begin
                    count_d = count_q + CNT_W'(1);
                    index_d = '0;
                    t_load  = 1'b1;
                    t_val   = STEP_LD;
                    state_d = S_PLAY_ON;
                end
            end
            S_PLAY_ON: begin
                t_en = 1'b1;
                if (t_expired) begin
                    t_load  = 1'b1;
                    t_val   = GAP_LD;
                    state_d = S_PLAY_GAP;
                end
            end
            S_PLAY_GAP: begin
                t_en = 1'b1;
                if (t_expired) begin
                    t_load = 1'b1;
                    if (more) begin
                        index_d = index_q + ADDR_W'(1);
                        t_val   = STEP_LD;
                        state_d = S_PLAY_ON;
                    end else begin
                        index_d = '0;
                        t_val   = TO_LD;
                        state_d = S_REPEAT;
                    end
                end
            end
            S_REPEAT: begin
                t_en = 1'b1;
                // A strobe in the expiry cycle wins over the timeout.
                if (legal) begin
                    if (pattern == mem_rdata) begin
                        if (more) begin
                            index_d = index_q + ADDR_W'(1);
                            t_load  = 1'b1;
                            t_val   = TO_LD;
                        end else begin
                            index_d   = '0;
                            retries_d = RETRY_INIT;
                            state_d   = (count_q == CNT_W'(DEPTH))
                                      ? S_WIN : S_INPUT;
                        end
                    end else begin
                        miss = 1'b1;
                    end
                end else if (TIMEOUT_TICKS != 0 && t_expired) begin
                    miss = 1'b1;
                end
                if (miss) begin
                    index_d = '0;
                    t_load  = 1'b1;
                    t_val   = STEP_LD;
                    if (retry_mode && retries_q != '0) begin
                        retries_d = retries_q - RW'(1);
                        state_d   = S_PLAY_ON;
                    end else begin
                        fail_on_d = 1'b1;
                        state_d   = S_FAIL;
                    end
                end
            end
            S_FAIL: begin
                t_en = 1'b1;
                // fail_on tracks the on/gap phase of the endless replay.
                if (t_expired) begin
                    t_load = 1'b1;
                    if (fail_on_q) begin
                        t_val     = GAP_LD;
                        fail_on_d = 1'b0;
                    end else begin
                        index_d   = more ? index_q + ADDR_W'(1) : '0;
                        t_val     = STEP_LD;
                        fail_on_d = 1'b1;
                    end
                end
            end
            S_WIN: begin
            end
            default: begin
                state_d = S_INPUT;
            end
        endcase
    end

    always_comb begin
        mem_addr  = index_q;
        w_en      = 1'b0;
        disp_en   = 1'b0;
        mode_leds = LED_MODE_INPUT;
        game_over = 1'b0;
        unique case (state_q)
            S_INPUT: begin
                mem_addr = ADDR_W'(count_q);
                w_en     = legal && !rst;
            end
            S_PLAY_ON: begin
                disp_en   = 1'b1;
                mode_leds = LED_MODE_PLAY;
            end
            S_PLAY_GAP: begin
                mode_leds = LED_MODE_PLAY;
            end
            S_REPEAT: begin
                mode_leds = LED_MODE_REPEAT;
            end
            S_FAIL: begin
                disp_en   = fail_on_q;
                mode_leds = LED_MODE_FAIL;
                game_over = 1'b1;
            end
            S_WIN: begin
                mode_leds = LED_MODE_WIN;
                game_over = 1'b1;
            end
            default: begin
                mode_leds = LED_MODE_INPUT;
            end
        endcase
    end

    assign mem_wdata    = pattern;
    assign disp_pattern = mem_rdata;
    assign count        = count_q;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Directed bench for simon_seq_ctrl with a write scoreboard and playback checks.
module tb_simon_seq_ctrl;

    localparam int DEPTH = 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [3:0]    pattern;
    logic          pattern_stb;
    logic          retry_mode;
    logic [3:0]    mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wdata;
    logic          w_en;
    logic          disp_en;
    logic [3:0]    disp_pattern;
    logic [CW-1:0] count;
    logic [2:0]    mode_leds;
    logic          game_over;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [3:0]    d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [3:0] mem[4];
    logic [3:0] seq[3];
    int         vectors = 0;
    int         miscompares = 0;

    simon_seq_ctrl #(
        .PAT_W(4), .DEPTH(DEPTH), .STEP_TICKS(8), .GAP_TICKS(2),
        .TIMEOUT_TICKS(64), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .rst(rst), .pattern(pattern),
        .pattern_stb(pattern_stb), .retry_mode(retry_mode),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .w_en(w_en), .disp_en(disp_en),
        .disp_pattern(disp_pattern), .count(count),
        .mode_leds(mode_leds), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (w_en) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: every write the DUT makes must match a queued one.
    always @(negedge clk) begin
        if (!rst && w_en) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", 16'(w_en), 16'd0);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("wr", 16'({mem_addr, mem_wdata}), 16'({e.a, e.d}));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pattern_stb = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
    endtask

    task automatic submit(input logic [3:0] p);
        pattern = p;
        pattern_stb = 1'b1;
        wait_cyc(1);
        pattern_stb = 1'b0;
    endtask

    task automatic submit_input(input logic [3:0] p, input int a);
        exp_wr.push_back('{a: AW'(a), d: p});
        seq[a] = p;
        pattern = p;
        pattern_stb = 1'b1;
        #1;
        chk("w_en_comb", 16'(w_en), 16'd1);
        chk("addr_comb", 16'(mem_addr), 16'(a));
        wait_cyc(1);
        pattern_stb = 1'b0;
        chk("count_inc", 16'(count), 16'(a + 1));
    endtask

    task automatic playback(input int n, input logic [2:0] led,
                            input bit noise);
        if (noise) begin
            pattern = 4'b0001;
            pattern_stb = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                chk("play_on", 16'({disp_en, disp_pattern, mode_leds}),
                    16'({1'b1, seq[i], led}));
                wait_cyc(1);
            end
            for (int k = 0; k < 2; k++) begin
                chk("play_gap", 16'({disp_en, mode_leds}), 16'({1'b0, led}));
                wait_cyc(1);
            end
        end
        pattern_stb = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 4'b0000;
        rst = 1'b1;
        pattern = 4'b0000;
        pattern_stb = 1'b0;
        retry_mode = 1'b0;
        wait_cyc(2);
        chk("rst_leds", 16'(mode_leds), 16'b001);
        chk("rst_outs", 16'({w_en, disp_en, game_over, mem_addr}), 16'd0);
        chk("rst_count", 16'(count), 16'd0);
        rst = 1'b0;
        wait_cyc(1);

        submit(4'b0000);
        submit(4'b0110);
        chk("illegal_in", 16'({count, mode_leds}), 16'({CW'(0), 3'b001}));

        submit_input(4'b0010, 0);
        playback(1, 3'b010, 1'b1);
        chk("repeat_mode", 16'(mode_leds), 16'b100);
        submit(4'b0010);
        chk("round1_done", 16'({count, mode_leds}), 16'({CW'(1), 3'b001}));

        submit_input(4'b1000, 1);
        playback(2, 3'b010, 1'b0);
        submit(4'b0010);
        submit(4'b1000);
        chk("round2_done", 16'({count, mode_leds}), 16'({CW'(2), 3'b001}));

        submit_input(4'b0100, 2);
        playback(3, 3'b010, 1'b0);
        submit(4'b0110);
        chk("illegal_rep", 16'(mode_leds), 16'b100);
        retry_mode = 1'b1;
        submit(4'b0010);
        submit(4'b0001);
        playback(3, 3'b010, 1'b0);
        submit(4'b0001);
        playback(3, 3'b010, 1'b0);
        submit(4'b0010);
        submit(4'b1000);
        submit(4'b0001);
        chk("fail_mode", 16'({game_over, mode_leds}), 16'({1'b1, 3'b111}));
        playback(3, 3'b111, 1'b1);
        playback(1, 3'b111, 1'b0);
        retry_mode = 1'b0;

        do_reset();
        submit_input(4'b0100, 0);
        playback(1, 3'b010, 1'b0);
        wait_cyc(63);
        chk("to_pre", 16'(mode_leds), 16'b100);
        wait_cyc(1);
        chk("to_fail", 16'(mode_leds), 16'b111);

        do_reset();
        submit_input(4'b0100, 0);
        playback(1, 3'b010, 1'b0);
        wait_cyc(63);
        submit(4'b0100);
        chk("to_stb", 16'({count, mode_leds}), 16'({CW'(1), 3'b001}));

        submit_input(4'b0001, 1);
        playback(2, 3'b010, 1'b0);
        submit(4'b0100);
        submit(4'b0001);
        submit_input(4'b1000, 2);
        playback(3, 3'b010, 1'b0);
        submit(4'b0100);
        submit(4'b0001);
        submit(4'b1000);
        chk("win", 16'({game_over, disp_en, count, mode_leds}),
            16'({1'b1, 1'b0, CW'(3), 3'b011}));
        submit(4'b0010);
        wait_cyc(3);
        chk("win_hold", 16'(mode_leds), 16'b011);

        do_reset();
        submit_input(4'b0010, 0);
        wait_cyc(3);
        chk("mid_play", 16'(disp_en), 16'd1);
        rst = 1'b1;
        pattern = 4'b0001;
        pattern_stb = 1'b1;
        wait_cyc(1);
        chk("rst_abort", 16'({count, mode_leds}), 16'({CW'(0), 3'b001}));
        chk("rst_wen", 16'(w_en), 16'd0);
        rst = 1'b0;
        pattern_stb = 1'b0;
        wait_cyc(2);
        chk("sb_empty", 16'(exp_wr.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/simon_seq_ctrl.md
Name: simon_seq_ctrl

Overview:
Parametrised next-generation Simon game controller that owns the round counter, index counter and step timers that previously lived in the datapath. Generalises pattern width and sequence depth, and adds timed playback, a response timeout, a retry mode, and distinct WIN/FAIL end states. Sits between the button/LED datapath and an external async-read pattern memory (DEPTH x PAT_W).

Parameters:
PAT_W, 4, pattern width (one bit per button/LED)
DEPTH, 16, max sequence length; reaching it wins the game
STEP_TICKS, 8, cycles each pattern is displayed during playback (>=1)
GAP_TICKS, 2, blank cycles between displayed patterns (>=1)
TIMEOUT_TICKS, 64, idle cycles allowed per REPEAT entry; 0 disables the timeout
MAX_RETRIES, 2, mismatches forgiven per round when retry_mode=1
ADDR_W, $clog2(DEPTH), memory address width
CNT_W, $clog2(DEPTH+1), round count width

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset; synchronous, active-high
pattern  in  PAT_W  user pattern from switches/buttons
pattern_stb  in  1  single-cycle submit strobe
retry_mode  in  1  1 = mismatch replays the round while retries remain; sampled at the mismatch
mem_rdata  in  PAT_W  memory read data, valid in the same cycle as mem_addr
mem_addr  out  ADDR_W  memory address (write and read)
mem_wdata  out  PAT_W  write data (= pattern)
w_en  out  1  memory write enable
disp_en  out  1  drive disp_pattern onto the LEDs
disp_pattern  out  PAT_W  pattern shown during playback (= mem_rdata)
count  out  CNT_W  current sequence length
mode_leds  out  3  INPUT 001, PLAY 010, REPEAT 100, FAIL 111, WIN 011
game_over  out  1  high in FAIL or WIN

Behaviour:
- Legal submission: pattern_stb=1 and pattern is one-hot. Illegal strobes are ignored in every state. Strobes during PLAY_ON, PLAY_GAP, FAIL and WIN are ignored.
- Reset: state INPUT, count=0, index=0, timer=0, retries=MAX_RETRIES. Outputs: w_en=0, disp_en=0, mode_leds=001, game_over=0, mem_addr=0. A reset mid-game aborts from any state in one cycle.
- Outputs are decoded from the registered state (Moore), except w_en, mem_addr and mem_wdata in INPUT, which follow the legal strobe combinationally. w_en is forced to 0 while rst=1.
- INPUT: mem_addr=count. On a legal strobe: w_en=1 for that cycle writes mem[count]=pattern; next cycle count+1, index=0, timer=STEP_TICKS-1, go to PLAY_ON.
- PLAY_ON: mem_addr=index, disp_en=1, disp_pattern=mem_rdata. Timer decrements. At timer==0, load GAP_TICKS-1 and go to PLAY_GAP. Each pattern is shown for exactly STEP_TICKS cycles.
- PLAY_GAP: disp_en=0, mode_leds=010. At timer==0:
  - if index+1<count: index+1, go to PLAY_ON;
  - otherwise: index=0, timer=TIMEOUT_TICKS-1, go to REPEAT.
- REPEAT: mem_addr=index. On a legal strobe, compare pattern==mem_rdata.
  - Match with index+1<count: index+1, timer reloads.
  - Match with index+1==count: index=0, retries=MAX_RETRIES. If count==DEPTH go to WIN, else go to INPUT.
  - Mismatch: if retry_mode=1 and retries>0, retries-1, index=0, go to PLAY_ON. Otherwise go to FAIL.
  - Timeout: with TIMEOUT_TICKS!=0, timer reaching 0 with no legal strobe is treated as a mismatch. A strobe in the expiry cycle takes priority over the timeout.
- FAIL: mode_leds=111. Endlessly replays the full sequence using PLAY_ON/PLAY_GAP timing with index wrapping to 0. Exits only on reset.
- WIN: mode_leds=011, disp_en=0. Exits only on reset.
- Arithmetic: counters and timers are unsigned. count never exceeds DEPTH. index never reaches count. The timer width covers max(STEP_TICKS, GAP_TICKS, TIMEOUT_TICKS).

Decomposition:
- simon_pkg holds the state enum (INPUT, PLAY_ON, PLAY_GAP, REPEAT, FAIL, WIN) and the LED_MODE_* constants.
- Sub-module simon_tick_timer: loadable down-counter with load value, enable and expired (==0) flag. Instantiated once and shared across states.

Test Plan:
- Reset, then strobe 4'b0010 -> w_en pulses 1 cycle, addr 0, wdata 0010; count=1; disp_en high 8 cycles showing 0010; gap 2 cycles; mode_leds=100.
- Round 1 repeat 0010, then enter 4'b1000 -> playback shows 0010 then 1000, each 8 on / 2 off; correct repeat returns to INPUT with count=2.
- retry_mode=1, count=2, wrong second entry -> full replay, retries 2->1. Third mismatch (retries=0) -> FAIL, mode_leds=111, looping playback.
- Strobes with 4'b0000, 4'b0110 and any strobe during playback -> no state change, no w_en.
- TIMEOUT_TICKS=64, no input in REPEAT with retry_mode=0 -> FAIL exactly 64 cycles after REPEAT entry. Strobe in the expiry cycle -> evaluated as normal input.
- DEPTH=3, complete 3 rounds -> WIN, mode_leds=011, game_over=1. Assert rst mid-PLAY_ON -> INPUT, count=0 the next cycle.
